// File: rtl/elm_onehot_argmax.sv
// ELM output stage: captures the class scores and scans them serially
// for the maximum, returning one-hot, index and winning score.
module elm_onehot_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DW          = 16,
    parameter int IDXW        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_out,
    input  logic [NUM_CLASSES*DW-1:0] yhat_flat,
    input  logic                      start_onehot,
    output logic                      output_valid,
    output logic [NUM_CLASSES-1:0]    onehot_out,
    output logic [IDXW-1:0]           class_idx,
    output logic [DW-1:0]             best_score,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0] scores [NUM_CLASSES];
    logic [IDXW-1:0]      cnt;
    logic [IDXW-1:0]      run_idx;
    logic signed [DW-1:0] run_max;

    logic signed [DW-1:0] cand;
    logic signed [DW-1:0] first_score;
    logic signed [DW-1:0] new_max;
    logic [IDXW-1:0]      new_idx;
    logic                 take;
    logic                 last;
    logic                 capture;

    always_comb begin
        cand        = scores[cnt];
        take        = cand > run_max;
        last        = cnt == IDXW'(NUM_CLASSES - 1);
        capture     = store_out && (state == IDLE || state == WAIT);
        // same-cycle capture: scan must start from the incoming data
        first_score = store_out ? $signed(yhat_flat[DW-1:0]) : scores[0];
        new_max     = take ? cand : run_max;
        new_idx     = take ? cnt : run_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        output_valid = 1'b0;
        busy         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_onehot) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (!start_onehot) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                output_valid = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (!start_onehot) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                scores[k] <= '0;
            end
            cnt        <= '0;
            run_idx    <= '0;
            run_max    <= '0;
            class_idx  <= '0;
            best_score <= '0;
            onehot_out <= '0;
        end else begin
            if (capture) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    scores[k] <= yhat_flat[k*DW +: DW];
                end
            end
            unique case (state)
                IDLE: begin
                    if (start_onehot) begin
                        run_max <= first_score;
                        run_idx <= '0;
                        cnt     <= IDXW'(1);
                    end
                end
                SCAN: begin
                    // a dropped request aborts without touching results
                    if (start_onehot) begin
                        run_max <= new_max;
                        run_idx <= new_idx;
                        cnt     <= cnt + IDXW'(1);
                        if (last) begin
                            class_idx  <= new_idx;
                            best_score <= new_max;
                            onehot_out <= {{(NUM_CLASSES-1){1'b0}}, 1'b1}
                                          << new_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_elm_onehot_argmax.sv
// Scoreboard bench for elm_onehot_argmax: a reference argmax model
// queues expected results; a monitor checks each output_valid pulse.
module tb_elm_onehot_argmax;

    localparam int N    = 10;
    localparam int DW   = 16;
    localparam int IDXW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              store_out;
    logic [N*DW-1:0]   yhat_flat;
    logic              start_onehot;
    logic              output_valid;
    logic [N-1:0]      onehot_out;
    logic [IDXW-1:0]   class_idx;
    logic [DW-1:0]     best_score;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [IDXW-1:0] exp_idx_q [$];
    logic [DW-1:0]   exp_score_q [$];

    logic [N*DW-1:0] bufm;
    logic [IDXW-1:0] last_idx;
    logic [DW-1:0]   last_score;
    logic [N-1:0]    last_onehot;

    elm_onehot_argmax #(.NUM_CLASSES(N), .DW(DW), .IDXW(IDXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .store_out    (store_out),
        .yhat_flat    (yhat_flat),
        .start_onehot (start_onehot),
        .output_valid (output_valid),
        .onehot_out   (onehot_out),
        .class_idx    (class_idx),
        .best_score   (best_score),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: first index holding the largest signed score.
    function automatic void model(input logic [N*DW-1:0] v,
                                  output logic [IDXW-1:0] idx,
                                  output logic [DW-1:0] sc);
        int best_k = 0;
        int best_v = $signed(v[DW-1:0]);
        for (int k = 1; k < N; k++) begin
            int s = $signed(v[k*DW +: DW]);
            if (s > best_v) begin
                best_v = s;
                best_k = k;
            end
        end
        idx = IDXW'(best_k);
        sc  = DW'(best_v);
    endfunction

    always @(negedge clk) begin
        if (!rst && output_valid) begin
            if (exp_idx_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                logic [IDXW-1:0] ei;
                logic [DW-1:0]   es;
                logic [N-1:0]    eo;
                ei = exp_idx_q.pop_front();
                es = exp_score_q.pop_front();
                eo = '0;
                eo[ei] = 1'b1;
                check("class_idx", class_idx, ei);
                check("best_score", best_score, es);
                check("onehot_out", onehot_out, eo);
            end
        end
    end

    function automatic logic [N*DW-1:0] pack(input int s [N]);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(s[k]);
        return v;
    endfunction

    task automatic store(input logic [N*DW-1:0] v);
        @(negedge clk);
        store_out = 1'b1;
        yhat_flat = v;
        bufm      = v;
        @(negedge clk);
        store_out = 1'b0;
    endtask

    task automatic push_exp(input logic [N*DW-1:0] v);
        logic [IDXW-1:0] ei;
        logic [DW-1:0]   es;
        model(v, ei, es);
        exp_idx_q.push_back(ei);
        exp_score_q.push_back(es);
        last_idx    = ei;
        last_score  = es;
        last_onehot = '0;
        last_onehot[ei] = 1'b1;
    endtask

    // Full run; optionally captures v in the same cycle as the request.
    task automatic run(input bit same, input logic [N*DW-1:0] v,
                       input bit scan_store, input logic [N*DW-1:0] junk);
        int k;
        bit got;
        @(negedge clk);
        if (same) begin
            store_out = 1'b1;
            yhat_flat = v;
            bufm      = v;
        end
        start_onehot = 1'b1;
        push_exp(bufm);
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            store_out = 1'b0;
            k++;
            if (scan_store && k == 3) begin
                store_out = 1'b1;
                yhat_flat = junk;
            end
            if (output_valid) got = 1'b1;
        end
        store_out = 1'b0;
        check("valid_latency", got ? k : -1, N);
        repeat (3) @(negedge clk);
        check("wait_not_busy", busy, 0);
        start_onehot = 1'b0;
        @(negedge clk);
    endtask

    logic [N*DW-1:0] none = '0;

    initial begin
        int s [N];
        rst          = 1'b1;
        store_out    = 1'b0;
        start_onehot = 1'b0;
        yhat_flat    = '0;
        bufm         = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", output_valid, 0);
        check("rst_onehot", onehot_out, 0);
        check("rst_idx", class_idx, 0);
        check("rst_score", best_score, 0);
        check("rst_busy", busy, 0);

        s = '{5, -3, 12, 40, 7, 0, -100, 39, 1, 2};
        store(pack(s));
        run(0, none, 0, none);
        check("dir_idx3", class_idx, 3);
        check("dir_onehot", onehot_out, 10'b0000001000);

        s = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
        store(pack(s));
        run(0, none, 0, none);

        s = '{1, 2, 3, 0, 9, -9, 5, 4, 9, 8};
        store(pack(s));
        run(0, none, 0, none);

        for (int k = 0; k < N; k++) s[k] = -32768;
        s[9] = 32767;
        store(pack(s));
        run(0, none, 0, none);

        // abort: request dropped during the 4th scan cycle
        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
        store(pack(s));
        @(negedge clk);
        start_onehot = 1'b1;
        repeat (4) @(negedge clk);
        start_onehot = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_idx", class_idx, last_idx);
        check("abort_score", best_score, last_score);
        check("abort_onehot", onehot_out, last_onehot);
        check("abort_busy", busy, 0);

        // store during scan is ignored
        s = '{1, 50, 2, 3, 4, 5, 6, 7, 8, 9};
        store(pack(s));
        s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 500};
        run(0, none, 1, pack(s));

        // store and start in the same idle cycle
        s = '{1, 2, 3, 4, 5, 600, 7, 8, 9, 10};
        run(1, pack(s), 0, none);

        // back-to-back images
        s = '{1, 2, 77, 4, 5, 6, 7, 8, 9, 10};
        store(pack(s));
        run(0, none, 0, none);
        s = '{1, 2, 3, 4, 5, 6, 7, 88, 9, 10};
        store(pack(s));
        run(0, none, 0, none);

        // reset mid-scan clears everything
        @(negedge clk);
        start_onehot = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        start_onehot = 1'b0;
        bufm         = '0;
        check("mrst_onehot", onehot_out, 0);
        check("mrst_idx", class_idx, 0);
        check("mrst_score", best_score, 0);
        check("mrst_busy", busy, 0);
        s = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        store(pack(s));
        run(0, none, 0, none);

        for (int it = 0; it < 30; it++) begin
            logic [N*DW-1:0] v;
            for (int k = 0; k < N; k++) begin
                if (it % 2 == 0) v[k*DW +: DW] = DW'($urandom);
                else v[k*DW +: DW] = DW'($urandom_range(0, 3)) - DW'(2);
            end
            if ($urandom_range(0, 1) == 1) begin
                run(1, v, 0, none);
            end else begin
                store(v);
                run(0, none, 0, none);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_idx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
